fc_result_layer: RTL and testbench
==================================

Name: fc_result_layer

Overview:
- Final fully-connected layer of the LeNet-5 datapath: 84 flattened features × 10 class scores.
- Reads features and weights from synchronous memories, one MAC per cycle, and writes the 10 scores into the 10-entry result memory.
- `done` drives the `en` of the downstream argmax stage, which reads result addresses 0-9.

Parameters:
- DATA_WIDTH, 16: signed fixed-point word width of features, weights, biases and scores.
- FRAC_BITS, 8: fractional bits (Q8.8 by default).
- IN_NUM, 84: input features per neuron.
- OUT_NUM, 10: output neurons.
- IN_ADDR_W, 7: feature address width; must satisfy 2^IN_ADDR_W >= IN_NUM.
- W_ADDR_W, 10: weight address width; must satisfy 2^W_ADDR_W >= OUT_NUM*(IN_NUM+1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  level enable; high = run/hold result, low = abort and return to IDLE.
- in_read_addr  out  IN_ADDR_W  feature memory address.
- in_data  in  DATA_WIDTH  feature word, valid 1 cycle after address.
- weight_read_addr  out  W_ADDR_W  weight/bias memory address.
- weight_data  in  DATA_WIDTH  weight/bias word, valid 1 cycle after address.
- result_wr_en  out  1  result memory write strobe.
- result_wr_addr  out  4  result memory address (neuron index).
- result_wr_data  out  DATA_WIDTH  score to write.
- done  out  1  all OUT_NUM scores written; held while en high.

Behaviour:
- Weight memory layout: neuron o occupies OUT base o*(IN_NUM+1).
  - Words base+0 .. base+IN_NUM-1 are weights for features 0 .. IN_NUM-1.
  - Word base+IN_NUM is the bias.
- Reset (rst=0, async): state=IDLE; acc, indices, base, pipeline flags = 0; all outputs = 0.
- FSM states: IDLE, MAC, DRAIN, WRITE, DONE.
- IDLE: en=1 -> MAC with o=0, i=0, base=0, acc=0.
- MAC: drive in_read_addr=i (i<IN_NUM; 0 when i=IN_NUM) and weight_read_addr=base+i.
  - Register pv=1, and pb=(i==IN_NUM).
  - i==IN_NUM -> DRAIN; otherwise i++.
- Accumulate every cycle pv=1 (data belongs to the previous cycle's address):
  - pb=0: acc += signed(in_data)*signed(weight_data).
  - pb=1: acc += sign_extend(weight_data)<<<FRAC_BITS.
- DRAIN: pv=0 after this cycle; absorbs the last (bias) term; -> WRITE.
- WRITE: result_wr_en=1 (combinational from state), result_wr_addr=o, result_wr_data=score(acc). Then clear acc and i.
  - o==OUT_NUM-1 -> DONE.
  - Otherwise o++, base+=IN_NUM+1, -> MAC.
- DONE: done=1; result_wr_en=0; stays while en=1.
  - en=0 -> IDLE, done=0 next cycle.
  - A new run requires en low for ≥1 cycle.
- Accumulator width: 2*DATA_WIDTH+8 signed; no overflow possible for IN_NUM ≤ 256.
- score(acc) = acc>>>FRAC_BITS (arithmetic), then clamped:
  - Negative -> 0. Downstream argmax compares unsigned, so scores must be non-negative.
  - Upper end: truncated to DATA_WIDTH bits, unless FC_SAT_EN is defined.
- Latency:
  - Each neuron takes IN_NUM+3 cycles (87).
  - done rises OUT_NUM*(IN_NUM+3) = 870 edges after the edge sampling en=1 in IDLE.
  - Writes occur at edges 87k, k=1..10, addresses 0..9 in order.
- en dropped mid-run (any non-IDLE state): next edge -> IDLE, acc/pv cleared, no further writes. Scores already written remain in memory. done is never asserted for an aborted run.
- en=1 with rst=0: reset dominates.
- Address outputs in IDLE, WRITE and DONE: 0.

Optional Feature:
- Macro FC_SAT_EN.
- Defined: positive scores above 2^(DATA_WIDTH-1)-1 saturate to 2^(DATA_WIDTH-1)-1 (0x7FFF).
- Undefined: the low DATA_WIDTH bits of the shifted acc are written, with wrap. Negative clamp to 0 applies in both builds.

Test Plan:
- Reset/idle: rst=0 mid-MAC, hold en=1 -> all outputs 0 immediately; after release, run restarts from neuron 0, address 0.
- Bias only: all weights 0, bias_o=o*256 -> writes data o*256 to addresses 0..9 at edges 87..870; done high from edge 870.
- Single term: in_data=0x0100 everywhere, weight[o*85+3]=0x0200 for o=5 only, biases 0 -> addr5=0x0200, all others 0.
- Negative clamp: bias_2=0xFF00 (-1.0), all weights 0 -> addr2 data 0x0000.
- Overflow: 84 terms of 0x7F00*0x7F00:
  - With FC_SAT_EN -> 0x7FFF.
  - Without -> truncated low 16 bits of the positive shifted acc; a wrapped value with the sign bit set is written as-is (only a negative acc is clamped).
- Abort: drop en at edge 300 -> writes seen only at addresses 0..2, done stays 0, FSM in IDLE at edge 301. Re-raise en -> full 870-cycle run.

Source files
------------

// File: rtl/fc_result_layer.sv
// -----------------------------------------------------------------------------
// fc_result_layer
//
// Final fully-connected layer of the LeNet-5 datapath (IN_NUM features x
// OUT_NUM class scores). Features and weights come from synchronous memories
// (data valid one cycle after the address). One multiply-accumulate is done
// per cycle. Each finished score is written to the result memory at the
// neuron's index.
//
// Weight memory layout: neuron o starts at base = o*(IN_NUM+1).
//   base+0 .. base+IN_NUM-1 : weights for features 0 .. IN_NUM-1
//   base+IN_NUM             : bias
//
// Ports
//   clk              in   clock, all state on the rising edge
//   rst              in   asynchronous, active-low reset
//   en               in   level enable: high = run / hold result,
//                         low = abort and return to IDLE
//   in_read_addr     out  feature memory address
//   in_data          in   feature word (Q format, FRAC_BITS fractional)
//   weight_read_addr out  weight/bias memory address
//   weight_data      in   weight/bias word
//   result_wr_en     out  result memory write strobe
//   result_wr_addr   out  result memory address (neuron index)
//   result_wr_data   out  non-negative score to write
//   done             out  all OUT_NUM scores written; held while en is high
//
// Build option
//   FC_SAT_EN  When defined, positive scores above 2^(DATA_WIDTH-1)-1 saturate
//              to that value. When undefined, the low DATA_WIDTH bits are
//              written and may wrap. Negative scores become 0 in both builds.
// -----------------------------------------------------------------------------
module fc_result_layer #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int IN_NUM     = 84,
   parameter int OUT_NUM    = 10,
   parameter int IN_ADDR_W  = 7,
   parameter int W_ADDR_W   = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   output logic [IN_ADDR_W-1:0]  in_read_addr,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [W_ADDR_W-1:0]   weight_read_addr,
   input  logic [DATA_WIDTH-1:0] weight_data,
   output logic                  result_wr_en,
   output logic [3:0]            result_wr_addr,
   output logic [DATA_WIDTH-1:0] result_wr_data,
   output logic                  done
);

   localparam int ACC_W = 2*DATA_WIDTH + 8;
   localparam int IDX_W = $clog2(IN_NUM + 1);
   localparam int PRD_W = 2*DATA_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MAC,
      S_DRAIN,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                   state, state_nxt;
   logic [IDX_W-1:0]         i_idx;
   logic [3:0]               o_idx;
   logic [W_ADDR_W-1:0]      base;
   logic signed [ACC_W-1:0]  acc;
   logic                     pv;   // memory data this cycle belongs to a MAC address
   logic                     pb;   // that address was the bias word

   logic                     last_in;
   logic                     last_out;
   logic signed [PRD_W-1:0]  prod;
   logic signed [ACC_W-1:0]  term;
   logic [DATA_WIDTH-1:0]    score;

   assign last_in  = (i_idx == IDX_W'(IN_NUM));
   assign last_out = (o_idx == 4'(OUT_NUM - 1));

   // ---------------------------------------------------------------------------
   // Accumulator term: product of feature and weight, or the bias aligned to
   // the product's binary point (FRAC_BITS more fractional bits than a word).
   // ---------------------------------------------------------------------------
   assign prod = $signed(in_data) * $signed(weight_data);
   assign term = pb ? (ACC_W'($signed(weight_data)) <<< FRAC_BITS)
                    : ACC_W'(prod);

   // ---------------------------------------------------------------------------
   // Score: arithmetic shift by FRAC_BITS, taken as a slice of acc. Negative
   // scores are forced to 0 because the downstream argmax compares unsigned.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      score = acc[FRAC_BITS+DATA_WIDTH-1:FRAC_BITS];
      if (acc[ACC_W-1]) begin
         score = '0;
      end
`ifdef FC_SAT_EN
      else if (|acc[ACC_W-2:FRAC_BITS+DATA_WIDTH-1]) begin
         score = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
`else
      else begin
         score = acc[FRAC_BITS+DATA_WIDTH-1:FRAC_BITS];
      end
`endif
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of process order.
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // ---------------------------------------------------------------------------
   // FSM: next state. Dropping en aborts from any state.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      if (!en) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  state_nxt = S_MAC;
            S_MAC:   if (last_in) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_out ? S_DONE : S_MAC;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs. Addresses are only driven while in MAC.
   // ---------------------------------------------------------------------------
   always_comb begin
      in_read_addr     = '0;
      weight_read_addr = '0;
      result_wr_en     = 1'b0;
      result_wr_addr   = '0;
      result_wr_data   = '0;
      done             = 1'b0;
      case (state)
         S_MAC: begin
            in_read_addr     = last_in ? '0 : IN_ADDR_W'(i_idx);
            weight_read_addr = base + W_ADDR_W'(i_idx);
         end
         S_WRITE: begin
            // Gated by en so that an abort in this cycle writes nothing.
            result_wr_en   = en;
            result_wr_addr = o_idx;
            result_wr_data = score;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath: indices, weight base, accumulator and the one-cycle pipeline
   // flags that track the memory read latency.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i_idx <= '0;
         o_idx <= '0;
         base  <= '0;
         acc   <= '0;
         pv    <= 1'b0;
         pb    <= 1'b0;
      end else if (!en) begin
         i_idx <= '0;
         o_idx <= '0;
         base  <= '0;
         acc   <= '0;
         pv    <= 1'b0;
         pb    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               i_idx <= '0;
               o_idx <= '0;
               base  <= '0;
               acc   <= '0;
               pv    <= 1'b0;
               pb    <= 1'b0;
            end
            S_MAC: begin
               pv <= 1'b1;
               pb <= last_in;
               if (!last_in) i_idx <= i_idx + 1'b1;
               if (pv)       acc   <= acc + term;
            end
            S_DRAIN: begin
               // The bias word addressed by the last MAC cycle arrives now.
               pv <= 1'b0;
               pb <= 1'b0;
               if (pv) acc <= acc + term;
            end
            S_WRITE: begin
               acc   <= '0;
               i_idx <= '0;
               if (!last_out) begin
                  o_idx <= o_idx + 1'b1;
                  base  <= base + W_ADDR_W'(IN_NUM + 1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fc_result_layer.sv
// -----------------------------------------------------------------------------
// tb_fc_result_layer
//
// Directed bench for fc_result_layer with behavioural synchronous feature,
// weight and result memories. Every write is logged with its edge number,
// counted from the edge that samples en=1 in IDLE. Expected scores are
// hand-computed per scenario.
// -----------------------------------------------------------------------------
module tb_fc_result_layer;

   localparam int DW    = 16;
   localparam int IN_N  = 84;
   localparam int OUT_N = 10;
   localparam int NLAT  = IN_N + 3;   // cycles per neuron

   logic          clk;
   logic          rst;
   logic          en;
   logic [6:0]    in_read_addr;
   logic [DW-1:0] in_data;
   logic [9:0]    weight_read_addr;
   logic [DW-1:0] weight_data;
   logic          result_wr_en;
   logic [3:0]    result_wr_addr;
   logic [DW-1:0] result_wr_data;
   logic          done;

   fc_result_layer dut (
      .clk              (clk),
      .rst              (rst),
      .en               (en),
      .in_read_addr     (in_read_addr),
      .in_data          (in_data),
      .weight_read_addr (weight_read_addr),
      .weight_data      (weight_data),
      .result_wr_en     (result_wr_en),
      .result_wr_addr   (result_wr_addr),
      .result_wr_data   (result_wr_data),
      .done             (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural memories
   logic [DW-1:0] feat [0:127];
   logic [DW-1:0] wmem [0:1023];

   always @(posedge clk) begin
      in_data     <= feat[in_read_addr];
      weight_data <= wmem[weight_read_addr];
   end

   // Edge counter and write log
   int            gcnt      = 0;
   int            run_start = 0;
   int            wr_total  = 0;
   logic [3:0]    log_addr [0:127];
   logic [DW-1:0] log_data [0:127];
   int            log_edge [0:127];

   always @(posedge clk) begin
      gcnt <= gcnt + 1;
      if (rst && result_wr_en && wr_total < 128) begin
         log_addr[wr_total] <= result_wr_addr;
         log_data[wr_total] <= result_wr_data;
         log_edge[wr_total] <= gcnt - run_start;
         wr_total           <= wr_total + 1;
      end
   end

   int            n_assert = 0;
   int            n_fail   = 0;
   logic [DW-1:0] exp_data [0:OUT_N-1];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_in_addr"}, 64'(in_read_addr), 64'd0);
      check({tag, "_w_addr"},  64'(weight_read_addr), 64'd0);
      check({tag, "_wr_en"},   64'(result_wr_en), 64'd0);
      check({tag, "_wr_data"}, 64'(result_wr_data), 64'd0);
      check({tag, "_done"},    64'(done), 64'd0);
   endtask

   task automatic load_bias_only();
      for (int i = 0; i < 128; i++)  feat[i] = 16'h0100;
      for (int i = 0; i < 1024; i++) wmem[i] = 16'h0000;
      for (int o = 0; o < OUT_N; o++) begin
         wmem[o*(IN_N+1) + IN_N] = 16'(o * 256);
         exp_data[o] = 16'(o * 256);
      end
   endtask

   task automatic start_run(output int first_idx);
      @(negedge clk);
      run_start = gcnt;
      first_idx = wr_total;
      en = 1'b1;
   endtask

   task automatic wait_done(input string tag);
      bit found;
      found = 1'b0;
      for (int c = 0; c < 1200 && !found; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            found = 1'b1;
            check({tag, "_done_edge"}, 64'(gcnt - run_start - 1), 64'(OUT_N*NLAT));
         end
      end
      check({tag, "_done_seen"}, 64'(found), 64'd1);
   endtask

   task automatic check_writes(input string tag, input int first_idx, input int n);
      check({tag, "_wr_count"}, 64'(wr_total - first_idx), 64'(n));
      for (int k = 0; k < n; k++) begin
         check($sformatf("%s_addr[%0d]", tag, k), 64'(log_addr[first_idx+k]), 64'(k));
         check($sformatf("%s_edge[%0d]", tag, k), 64'(log_edge[first_idx+k]), 64'(NLAT*(k+1)));
         check($sformatf("%s_data[%0d]", tag, k), 64'(log_data[first_idx+k]), 64'(exp_data[k]));
      end
   endtask

   task automatic end_run();
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first;

      rst = 1'b0;
      en  = 1'b0;
      load_bias_only();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");

      // Reset asserted in the middle of MAC with en held high
      @(negedge clk);
      rst = 1'b1;
      start_run(first);
      repeat (20) @(posedge clk);
      #1;
      check("mid_mac_w_addr", 64'(weight_read_addr), 64'd19);
      check("mid_mac_in_addr", 64'(in_read_addr), 64'd19);
      #2;
      rst = 1'b0;
      #1;
      check_idle_outputs("async_rst");
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("rst_dominates_en");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("restart_in_addr0", 64'(in_read_addr), 64'd0);
      check("restart_w_addr0", 64'(weight_read_addr), 64'd0);
      @(posedge clk);
      #1;
      check("restart_in_addr1", 64'(in_read_addr), 64'd1);
      check("restart_w_addr1", 64'(weight_read_addr), 64'd1);
      end_run();

      // Bias only: neuron o scores o*256
      load_bias_only();
      start_run(first);
      wait_done("bias");
      check_writes("bias", first, OUT_N);
      repeat (5) @(posedge clk);
      #1;
      check("bias_done_held", 64'(done), 64'd1);
      check("bias_done_in_addr", 64'(in_read_addr), 64'd0);
      check("bias_done_wr_en", 64'(result_wr_en), 64'd0);
      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      #1;
      check("bias_done_drop", 64'(done), 64'd0);
      @(negedge clk);

      // Single term, signed term with feature addressing, negative clamp
      for (int i = 0; i < 128; i++)  feat[i] = 16'h0100;
      for (int i = 0; i < 1024; i++) wmem[i] = 16'h0000;
      feat[10] = 16'h0300;
      wmem[5*(IN_N+1) + 3]    = 16'h0200;   // 1.0 * 2.0
      wmem[2*(IN_N+1) + IN_N] = 16'hFF00;   // bias -1.0 -> clamped to 0
      wmem[7*(IN_N+1) + 10]   = 16'hFE00;   // 3.0 * -2.0 = -6.0
      wmem[7*(IN_N+1) + IN_N] = 16'h0700;   // + 7.0 -> 1.0
      for (int o = 0; o < OUT_N; o++) exp_data[o] = 16'h0000;
      exp_data[5] = 16'h0200;
      exp_data[7] = 16'h0100;
      start_run(first);
      wait_done("term");
      check_writes("term", first, OUT_N);
      end_run();

      // Overflow: 84 * (0x7F00*0x7F00) >>> 8 = 0x14AC5400
      for (int i = 0; i < 128; i++)  feat[i] = 16'h7F00;
      for (int i = 0; i < 1024; i++) wmem[i] = 16'h7F00;
      for (int o = 0; o < OUT_N; o++) wmem[o*(IN_N+1) + IN_N] = 16'h0000;
      wmem[1*(IN_N+1) + IN_N] = 16'h4000;   // lifts the low word to 0x9400
      for (int o = 0; o < OUT_N; o++) begin
`ifdef FC_SAT_EN
         exp_data[o] = 16'h7FFF;
`else
         exp_data[o] = (o == 1) ? 16'h9400 : 16'h5400;
`endif
      end
      start_run(first);
      wait_done("ovf");
      check_writes("ovf", first, OUT_N);
      end_run();

      // Abort: en sampled low at edge 300
      load_bias_only();
      start_run(first);
      repeat (300) @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      #1;
      check_idle_outputs("abort_idle");
      repeat (100) @(posedge clk);
      #1;
      check("abort_done_low", 64'(done), 64'd0);
      check_writes("abort", first, 3);

      // Re-raise en: full run from the start
      start_run(first);
      wait_done("rerun");
      check_writes("rerun", first, OUT_N);
      end_run();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
